// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-LED PWM driver that fades each LED toward its target brightness.
// Latency: pattern_in registered once; levels move on fade ticks; leds_out/fade_busy registered.
// Backpressure: none; pattern_in and max_level are level-sampled continuously.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pattern_in 8-bit on/off pattern, bit i drives LED i
//   max_level  brightness ceiling used as the "on" target (unregistered)
//   leds_out   PWM-modulated LED drive (registered)
//   fade_busy  high while any LED level differs from its target (registered, one cycle behind)
module led_pwm_fader #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int FADE_DIV  = CLK_FREQ / 1000,
  parameter int FADE_STEP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pattern_in,
  input  logic [7:0] max_level,
  output logic [7:0] leds_out,
  output logic       fade_busy
);

  // Tick counter needs at least one bit even when FADE_DIV == 1.
  localparam int            TW        = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FADE_DIV - 1);
  localparam logic [8:0]    STEP9     = 9'(FADE_STEP);

  logic [7:0]    pat_q;
  logic [7:0]    pwm_cnt_q;
  logic [7:0]    pwm_cnt_d;
  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick;

  logic [7:0] level_q [8];
  logic [7:0] level_d [8];
  logic [7:0] target  [8];
  logic [8:0] up_diff [8];
  logic [8:0] dn_diff [8];

  logic [7:0] leds_q;
  logic [7:0] leds_d;
  logic       busy_q;
  logic       busy_d;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    pwm_cnt_d  = pwm_cnt_q + 8'd1;
    busy_d     = 1'b0;
    leds_d     = '0;
    for (int i = 0; i < 8; i++) begin
      target[i]  = pat_q[i] ? max_level : 8'd0;
      // 9-bit differences so the step clamp can never wrap.
      up_diff[i] = {1'b0, target[i]} - {1'b0, level_q[i]};
      dn_diff[i] = {1'b0, level_q[i]} - {1'b0, target[i]};
      level_d[i] = level_q[i];
      // Compare uses the pre-update level, so a tick on a PWM wrap has no interaction.
      leds_d[i]  = (level_q[i] > pwm_cnt_q);
      busy_d     = busy_d | (level_q[i] != target[i]);
      if (tick) begin
        if (level_q[i] < target[i]) begin
          level_d[i] = level_q[i] + ((up_diff[i] > STEP9) ? STEP9[7:0] : up_diff[i][7:0]);
        end else if (level_q[i] > target[i]) begin
          level_d[i] = level_q[i] - ((dn_diff[i] > STEP9) ? STEP9[7:0] : dn_diff[i][7:0]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= '0;
      pwm_cnt_q  <= '0;
      tick_cnt_q <= '0;
      leds_q     <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      pat_q      <= pattern_in;
      pwm_cnt_q  <= pwm_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      leds_q     <= leds_d;
      busy_q     <= busy_d;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign leds_out  = leds_q;
  assign fade_busy = busy_q;

endmodule
